// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared definitions for the data-memory arbiter.
//   state_t  : arbiter FSM encoding (IDLE / ACCESS / DONE)
//   PORT_CPU : requester id of the CPU MEM stage (port 0)
//   PORT_DBG : requester id of the debug/loader (port 1)
package dmem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   localparam logic PORT_CPU = 1'b0;
   localparam logic PORT_DBG = 1'b1;

endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: requester handshake + data_memory pins of the arbiter.
//   req_x/we_x/addr_x/wdata_x : per-port request (from requesters)
//   done_x, rdata, busy       : completion side (to requesters)
//   mem_*                     : data_memory pins; mem_read_data comes back
// Modports:
//   slave  : the arbiter's view
//   master : the environment's view (requesters + memory)
interface dmem_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              req_0,   req_1;
   logic              we_0,    we_1;
   logic [ADDR_W-1:0] addr_0,  addr_1;
   logic [DATA_W-1:0] wdata_0, wdata_1;
   logic              done_0,  done_1;
   logic [DATA_W-1:0] rdata;
   logic              busy;
   logic [ADDR_W-1:0] mem_address;
   logic [DATA_W-1:0] mem_write_data;
   logic              mem_MemWrite;
   logic              mem_MemRead;
   logic [DATA_W-1:0] mem_read_data;

   modport slave (
      input  req_0, req_1, we_0, we_1, addr_0, addr_1, wdata_0, wdata_1,
      output done_0, done_1, rdata, busy,
      output mem_address, mem_write_data, mem_MemWrite, mem_MemRead,
      input  mem_read_data
   );

   modport master (
      output req_0, req_1, we_0, we_1, addr_0, addr_1, wdata_0, wdata_1,
      input  done_0, done_1, rdata, busy,
      input  mem_address, mem_write_data, mem_MemWrite, mem_MemRead,
      output mem_read_data
   );
endinterface

// File: rtl/dmem_rr_pick.sv
// dmem_rr_pick: combinational two-request picker.
//   req_0, req_1 : pending requests
//   last_grant   : port granted most recently
//   grant_valid  : at least one request pending
//   grant_id     : winning port
// A lone request always wins. On a conflict the port that was not granted
// last wins, unless FIXED_PRIO is set, in which case port 0 always wins.
module dmem_rr_pick
   import dmem_arb_pkg::*;
#(
   parameter bit FIXED_PRIO = 1'b0
) (
   input  logic req_0,
   input  logic req_1,
   input  logic last_grant,
   output logic grant_valid,
   output logic grant_id
);

   always_comb begin
      grant_valid = req_0 | req_1;
      grant_id    = PORT_CPU;
      if (req_0 && req_1)
         grant_id = FIXED_PRIO ? PORT_CPU : ~last_grant;
      else if (req_1)
         grant_id = PORT_DBG;
   end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares single-ported data_memory between the CPU MEM stage
// (port 0) and the debug/loader (port 1).
//   clk, reset_n : clock, synchronous active-low reset
//   bus          : dmem_arbiter_if.slave (requests, done pulses, rdata,
//                  busy, data_memory pins)
// Optional: `define DMEM_ARB_PERF_EN adds perf_cnt_0, perf_cnt_1 and
// perf_conflict (32-bit wrapping event counters).
// One transaction takes IDLE(grant) -> ACCESS -> DONE; all memory-side pins
// and done pulses come straight from flops.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter bit FIXED_PRIO = 1'b0
) (
   input  logic              clk,
   input  logic              reset_n,
   dmem_arbiter_if.slave     bus
`ifdef DMEM_ARB_PERF_EN
   ,
   output logic [31:0]       perf_cnt_0,
   output logic [31:0]       perf_cnt_1,
   output logic [31:0]       perf_conflict
`endif
);

   state_t            state, state_nxt;
   logic              last_grant;
   logic              win_id;
   logic              pick_valid, pick_id;
   logic              lat_we;
   logic [ADDR_W-1:0] lat_addr;
   logic [DATA_W-1:0] lat_wdata;
   logic [DATA_W-1:0] rdata_q;
   logic              mwr_q, mrd_q;
   logic              done0_q, done1_q;

   dmem_rr_pick #(.FIXED_PRIO(FIXED_PRIO)) u_pick (
      .req_0       (bus.req_0),
      .req_1       (bus.req_1),
      .last_grant  (last_grant),
      .grant_valid (pick_valid),
      .grant_id    (pick_id)
   );

   always_ff @(posedge clk) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (pick_valid) state_nxt = ACCESS;
         ACCESS:  state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Strobes and done are asserted one state ahead so they are registered
   // outputs aligned with ACCESS and DONE respectively.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         last_grant <= PORT_DBG;   // port 0 wins the first conflict
         win_id     <= PORT_CPU;
         lat_we     <= 1'b0;
         lat_addr   <= '0;
         lat_wdata  <= '0;
         rdata_q    <= '0;
         mwr_q      <= 1'b0;
         mrd_q      <= 1'b0;
         done0_q    <= 1'b0;
         done1_q    <= 1'b0;
      end else begin
         mwr_q   <= 1'b0;
         mrd_q   <= 1'b0;
         done0_q <= 1'b0;
         done1_q <= 1'b0;
         case (state)
            IDLE: begin
               if (pick_valid) begin
                  win_id    <= pick_id;
                  lat_we    <= pick_id ? bus.we_1    : bus.we_0;
                  lat_addr  <= pick_id ? bus.addr_1  : bus.addr_0;
                  lat_wdata <= pick_id ? bus.wdata_1 : bus.wdata_0;
                  mwr_q     <= pick_id ? bus.we_1    : bus.we_0;
                  mrd_q     <= pick_id ? !bus.we_1   : !bus.we_0;
               end
            end
            ACCESS: begin
               // memory read is combinational; capture at the end of ACCESS
               if (!lat_we) rdata_q <= bus.mem_read_data;
               done0_q <= (win_id == PORT_CPU);
               done1_q <= (win_id == PORT_DBG);
            end
            DONE:    last_grant <= win_id;
            default: ;
         endcase
      end
   end

   assign bus.busy           = (state != IDLE);
   assign bus.done_0         = done0_q;
   assign bus.done_1         = done1_q;
   assign bus.rdata          = rdata_q;
   assign bus.mem_address    = lat_addr;
   assign bus.mem_write_data = lat_wdata;
   assign bus.mem_MemWrite   = mwr_q;
   assign bus.mem_MemRead    = mrd_q;

`ifdef DMEM_ARB_PERF_EN
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         perf_cnt_0    <= '0;
         perf_cnt_1    <= '0;
         perf_conflict <= '0;
      end else begin
         if (state == DONE) begin
            if (win_id == PORT_DBG) perf_cnt_1 <= perf_cnt_1 + 32'd1;
            else                    perf_cnt_0 <= perf_cnt_0 + 32'd1;
         end
         if (state == IDLE && bus.req_0 && bus.req_1)
            perf_conflict <= perf_conflict + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: two arbiters (round-robin u_rr, fixed-priority u_fp), each
// with a small word memory. Stimulus pushes expected transactions (port,
// direction, address, data, done cycle) into a per-DUT queue; a negedge
// monitor checks strobes against the queue head and pops on each done.
module tb_dmem_arbiter;

   typedef struct {
      int          port;
      logic        we;
      logic [31:0] addr;
      logic [31:0] data;
      int          cyc;
   } exp_t;

   logic clk;
   logic reset_n;
   int   cyc;
   int   total;
   int   bad;
   exp_t sb_q[$];
   exp_t sb_f[$];
   logic [31:0] mem_r [16];
   logic [31:0] mem_f [16];

   dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bi ();
   dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bf ();

`ifdef DMEM_ARB_PERF_EN
   logic [31:0] pr0, pr1, prc, pf0, pf1, pfc;
`endif

   dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .FIXED_PRIO(1'b0)) u_rr (
      .clk(clk), .reset_n(reset_n), .bus(bi)
`ifdef DMEM_ARB_PERF_EN
      , .perf_cnt_0(pr0), .perf_cnt_1(pr1), .perf_conflict(prc)
`endif
   );

   dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .FIXED_PRIO(1'b1)) u_fp (
      .clk(clk), .reset_n(reset_n), .bus(bf)
`ifdef DMEM_ARB_PERF_EN
      , .perf_cnt_0(pf0), .perf_cnt_1(pf1), .perf_conflict(pfc)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // memory models: combinational read, write on the rising edge
   assign bi.mem_read_data = mem_r[bi.mem_address[3:0]];
   assign bf.mem_read_data = mem_f[bf.mem_address[3:0]];
   always @(posedge clk) begin
      if (!reset_n) begin
         for (int i = 0; i < 16; i++) begin
            mem_r[i] <= '0;
            mem_f[i] <= '0;
         end
      end else begin
         if (bi.mem_MemWrite) mem_r[bi.mem_address[3:0]] <= bi.mem_write_data;
         if (bf.mem_MemWrite) mem_f[bf.mem_address[3:0]] <= bf.mem_write_data;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got=%0h want=%0h (cyc %0d)", nm, act, want, cyc);
      end
   endtask

   task automatic push(input int d, input int p, input logic w,
                       input logic [31:0] a, input logic [31:0] dat, input int c);
      exp_t e;
      e.port = p; e.we = w; e.addr = a; e.data = dat; e.cyc = c;
      if (d == 0) sb_q.push_back(e);
      else        sb_f.push_back(e);
   endtask

   task automatic set_port(input int d, input int p, input logic r, input logic w,
                           input logic [31:0] a, input logic [31:0] wd);
      if (d == 0) begin
         if (p == 0) begin bi.req_0 = r; bi.we_0 = w; bi.addr_0 = a; bi.wdata_0 = wd; end
         else        begin bi.req_1 = r; bi.we_1 = w; bi.addr_1 = a; bi.wdata_1 = wd; end
      end else begin
         if (p == 0) begin bf.req_0 = r; bf.we_0 = w; bf.addr_0 = a; bf.wdata_0 = wd; end
         else        begin bf.req_1 = r; bf.we_1 = w; bf.addr_1 = a; bf.wdata_1 = wd; end
      end
   endtask

   function automatic logic get_done(input int d, input int p);
      if (d == 0) return (p == 0) ? bi.done_0 : bi.done_1;
      return (p == 0) ? bf.done_0 : bf.done_1;
   endfunction

   task automatic wait_done(input int d, input int p);
      logic seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         seen = get_done(d, p);
      end
      if (!seen) begin
         total++;
         bad++;
         $display("FAIL timeout dut%0d port%0d: got=no done want=done", d, p);
      end
   endtask

   // n back-to-back transactions, req held high between them; req drops in
   // the cycle after the last done.
   task automatic requester(input int d, input int p, input int n, input logic [31:0] a0,
                            input logic [31:0] d0, input logic w);
      for (int i = 0; i < n; i++) begin
         set_port(d, p, 1'b1, w, a0 + i, d0 + i);
         wait_done(d, p);
         @(posedge clk); #1;
      end
      set_port(d, p, 1'b0, w, a0, d0);
   endtask

   task automatic mon(input int d);
      exp_t e;
      int   qs;
      logic d0, d1, mw, mr;
      logic [31:0] ad, wd, rd;
      string tag;
      tag = (d == 0) ? "rr" : "fp";
      if (d == 0) begin
         d0 = bi.done_0; d1 = bi.done_1; mw = bi.mem_MemWrite; mr = bi.mem_MemRead;
         ad = bi.mem_address; wd = bi.mem_write_data; rd = bi.rdata; qs = sb_q.size();
         if (qs > 0) e = sb_q[0];
      end else begin
         d0 = bf.done_0; d1 = bf.done_1; mw = bf.mem_MemWrite; mr = bf.mem_MemRead;
         ad = bf.mem_address; wd = bf.mem_write_data; rd = bf.rdata; qs = sb_f.size();
         if (qs > 0) e = sb_f[0];
      end
      if (mw || mr) begin
         if (qs == 0) chk({tag, "_unexpected_strobe"}, 32'd1, 32'd0);
         else begin
            chk({tag, "_strobe_cycle"}, cyc, e.cyc - 1);
            chk({tag, "_MemWrite"}, {31'd0, mw}, {31'd0, e.we});
            chk({tag, "_MemRead"}, {31'd0, mr}, {31'd0, !e.we});
            chk({tag, "_mem_address"}, ad, e.addr);
            if (e.we) chk({tag, "_mem_write_data"}, wd, e.data);
         end
      end
      if (d0 || d1) begin
         chk({tag, "_done_overlap"}, {31'd0, d0 & d1}, 32'd0);
         if (qs == 0) chk({tag, "_unexpected_done"}, 32'd1, 32'd0);
         else begin
            chk({tag, "_done_port"}, {31'd0, d1}, e.port);
            chk({tag, "_done_cycle"}, cyc, e.cyc);
            if (!e.we) chk({tag, "_rdata"}, rd, e.data);
            if (d == 0) void'(sb_q.pop_front());
            else        void'(sb_f.pop_front());
         end
      end
   endtask

   always @(negedge clk) begin
      mon(0);
      mon(1);
   end

   initial begin
      #300000;
      $display("FAIL watchdog: got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      total = 0;
      bad   = 0;
      for (int d = 0; d < 2; d++)
         for (int p = 0; p < 2; p++) set_port(d, p, 1'b0, 1'b0, 32'd0, 32'd0);

      // reset held 2 cycles with a request pending
      reset_n = 1'b0;
      set_port(0, 0, 1'b1, 1'b0, 32'd5, 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_busy",        {31'd0, bi.busy},         32'd0);
      chk("rst_done_0",      {31'd0, bi.done_0},       32'd0);
      chk("rst_done_1",      {31'd0, bi.done_1},       32'd0);
      chk("rst_MemWrite",    {31'd0, bi.mem_MemWrite}, 32'd0);
      chk("rst_MemRead",     {31'd0, bi.mem_MemRead},  32'd0);
      chk("rst_mem_address", bi.mem_address,           32'd0);
      chk("rst_write_data",  bi.mem_write_data,        32'd0);
      chk("rst_rdata",       bi.rdata,                 32'd0);
      @(posedge clk); #1;
      reset_n = 1'b1;
      set_port(0, 0, 1'b0, 1'b0, 32'd0, 32'd0);
      @(posedge clk); #1;

      // single write then read on port 0
      push(0, 0, 1'b1, 32'd0, 32'd10, cyc + 2);
      requester(0, 0, 1, 32'd0, 32'd10, 1'b1);
      push(0, 0, 1'b0, 32'd0, 32'd10, cyc + 2);
      requester(0, 0, 1, 32'd0, 32'd0, 1'b0);

      // reset during ACCESS of a write to addr 3: no done, back to IDLE
      push(0, 0, 1'b1, 32'd3, 32'd33, cyc + 2);
      set_port(0, 0, 1'b1, 1'b1, 32'd3, 32'd33);
      @(posedge clk); #1;
      reset_n = 1'b0;
      set_port(0, 0, 1'b0, 1'b0, 32'd0, 32'd0);
      @(posedge clk); #1;
      reset_n = 1'b1;
      @(negedge clk);
      chk("abort_busy",     {31'd0, bi.busy},         32'd0);
      chk("abort_MemWrite", {31'd0, bi.mem_MemWrite}, 32'd0);
      chk("abort_MemRead",  {31'd0, bi.mem_MemRead},  32'd0);
      repeat (4) @(negedge clk);
      chk("abort_no_done", sb_q.size(), 32'd1);
      sb_q.delete();
      @(posedge clk); #1;

      // simultaneous writes: port 0 first (last_grant reset to 1), then port 1
      k = cyc;
      push(0, 0, 1'b1, 32'd1, 32'd20, k + 2);
      push(0, 1, 1'b1, 32'd2, 32'd30, k + 5);
      fork
         requester(0, 0, 1, 32'd1, 32'd20, 1'b1);
         requester(0, 1, 1, 32'd2, 32'd30, 1'b1);
      join
      push(0, 0, 1'b0, 32'd1, 32'd20, cyc + 2);
      requester(0, 0, 1, 32'd1, 32'd0, 1'b0);
      push(0, 1, 1'b0, 32'd2, 32'd30, cyc + 2);
      requester(0, 1, 1, 32'd2, 32'd0, 1'b0);

      // round-robin: both hold req for 4 transactions each -> 0,1,0,1,...
      k = cyc;
      for (int j = 0; j < 8; j++) begin
         if (j % 2 == 0) push(0, 0, 1'b1, 32'd4 + j / 2, 32'd40 + j / 2, k + 2 + 3 * j);
         else            push(0, 1, 1'b1, 32'd8 + j / 2, 32'd80 + j / 2, k + 2 + 3 * j);
      end
      fork
         requester(0, 0, 4, 32'd4, 32'd40, 1'b1);
         requester(0, 1, 4, 32'd8, 32'd80, 1'b1);
      join
      repeat (3) @(posedge clk); #1;

      // fixed priority: both high, port 0 served 3 times, port 1 then gives up
      k = cyc;
      for (int j = 0; j < 3; j++) push(1, 0, 1'b1, 32'd12 + j, 32'hC0 + j, k + 2 + 3 * j);
      set_port(1, 1, 1'b1, 1'b1, 32'd15, 32'hFF);
      requester(1, 0, 3, 32'd12, 32'hC0, 1'b1);
      set_port(1, 1, 1'b0, 1'b1, 32'd15, 32'hFF);
      repeat (4) @(negedge clk);

`ifdef DMEM_ARB_PERF_EN
      chk("fp_perf_cnt_0",    pf0, 32'd3);
      chk("fp_perf_cnt_1",    pf1, 32'd0);
      chk("fp_perf_conflict", pfc, 32'd3);
      chk("rr_perf_cnt_0",    pr0, 32'd6);
      chk("rr_perf_cnt_1",    pr1, 32'd6);
      chk("rr_perf_conflict", prc, 32'd8);
`endif
      chk("rr_queue_drained", sb_q.size(), 32'd0);
      chk("fp_queue_drained", sb_f.size(), 32'd0);
      chk("rr_idle_busy", {31'd0, bi.busy}, 32'd0);
      chk("fp_idle_busy", {31'd0, bf.busy}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-ported data_memory between two requesters: port 0 is the CPU MEM stage, port 1 is the debug/loader.
- Per-port req/done handshake; all memory-side signals are registered.
- Each transaction is one read or one 32-bit write.
- Sits between the requesters and data_memory and drives its address, write_data, MemWrite and MemRead pins directly.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- FIXED_PRIO, 0; 0 = round-robin, 1 = port 0 always wins a conflict.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  synchronous, active-low reset.
- req_0 / req_1  in  1  transaction request, level.
- we_0 / we_1  in  1  1 = write, 0 = read.
- addr_0 / addr_1  in  ADDR_W  word address.
- wdata_0 / wdata_1  in  DATA_W  write data.
- done_0 / done_1  out  1  one-cycle completion pulse.
- rdata  out  DATA_W  read result, shared by both ports.
- busy  out  1  high when state is not IDLE.
- mem_address  out  ADDR_W  to data_memory.address.
- mem_write_data  out  DATA_W  to data_memory.write_data.
- mem_MemWrite  out  1  to data_memory.MemWrite.
- mem_MemRead  out  1  to data_memory.MemRead.
- mem_read_data  in  DATA_W  from data_memory.read_data; combinational read.

Behaviour:
- Clock and reset: one clock, clk. reset_n is synchronous and active-low, sampled at the rising edge.
- Reset values: state = IDLE, last_grant = 1 (so port 0 wins the first conflict). All outputs 0.
- State IDLE:
  - Samples req_0 and req_1 on each edge.
  - One request high: that port wins.
  - Both high: the winner is the port not equal to last_grant. With FIXED_PRIO = 1, port 0 wins.
  - On the grant edge: latch the winner id, addr, wdata and we; go to ACCESS.
- State ACCESS (exactly 1 cycle):
  - mem_address and mem_write_data show the latched values.
  - mem_MemWrite = we, mem_MemRead = !we.
  - For a read, rdata captures mem_read_data on the edge that ends ACCESS.
  - Go to DONE.
- State DONE (exactly 1 cycle):
  - done_<winner> = 1.
  - mem_MemWrite = mem_MemRead = 0.
  - last_grant updates to the winner.
  - Go to IDLE.
- Latency: req sampled at edge t -> ACCESS in cycle t+1 -> done in cycle t+2. Peak throughput is one transaction per 3 cycles.
- Requester rules:
  - Hold req, we, addr and wdata stable from assertion until done.
  - Drop req in the cycle after done. If req is still high, it is a new request.
- req is ignored in ACCESS and DONE.
- A req that drops before its grant is simply not served.
- rdata holds its value until the next read completes; writes leave it unchanged.
- mem_address and mem_write_data keep their last values while idle; only the strobes return to 0.
- Reset mid-operation: at the reset edge the state returns to IDLE and the strobes go to 0. The aborted transaction produces no done. last_grant returns to 1.
- Exactly one done pulse per grant; done_0 and done_1 are never high together.

Optional Feature:
- Macro: DMEM_ARB_PERF_EN.
- Defined: adds three outputs, each 32-bit and reset to 0:
  - perf_cnt_0: completed port 0 transactions, incremented in DONE.
  - perf_cnt_1: completed port 1 transactions, incremented in DONE.
  - perf_conflict: IDLE cycles with both req high.
  - All three counters wrap modulo 2^32.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Package dmem_arb_pkg holds:
  - state encoding: IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2;
  - port id constants PORT_CPU = 1'b0, PORT_DBG = 1'b1.
- One natural sub-module: dmem_rr_pick, a combinational two-request picker.
  - Inputs: req_0, req_1, last_grant, FIXED_PRIO.
  - Outputs: grant_valid, grant_id.

Test Plan:
- Reset: reset_n = 0 for 2 cycles with req_0 = 1 -> all outputs 0, busy = 0, no done.
- Single write then read: port 0 writes addr 0, data 10 -> mem_MemWrite high for exactly 1 cycle with mem_address = 0 and mem_write_data = 10; done_0 at t+2. Port 0 then reads addr 0 -> done_0 at t+2 with rdata = 10.
- Simultaneous requests: port 0 writes addr 1 = 20 and port 1 writes addr 2 = 30 in the same cycle -> port 0 is served first (done_0 at t+2), port 1 next (done_1 at t+5). Read-back returns 20 and 30.
- Round-robin fairness: both ports hold req for 4 transactions each -> grant order 0,1,0,1,0,1,0,1; no back-to-back grants to the same port while the other waits.
- Reset during ACCESS of a write to addr 3 -> next cycle state = IDLE, strobes = 0, no done_0 or done_1, busy = 0.
- FIXED_PRIO = 1 with both req continuously high for 3 transactions -> port 0 granted every time. With DMEM_ARB_PERF_EN: perf_cnt_0 = 3, perf_cnt_1 = 0, perf_conflict = 3.
